// File: rtl/aes_req_arbiter_pkg.sv
// Shared types for the AES request arbiter: block type and FSM state encoding.
package aes_arb_pkg;
  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } arb_state_e;
endpackage

// File: rtl/aes_req_arbiter_if.sv
// Requester/consumer bus of the AES arbiter; master = clients, slave = arbiter.
interface aes_req_arbiter_if
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic       [NUM_REQ-1:0] req_valid;
  logic       [NUM_REQ-1:0] req_ready;
  aes_block_t [NUM_REQ-1:0] req_key;
  aes_block_t [NUM_REQ-1:0] req_data;
  logic                     resp_valid;
  logic                     resp_ready;
  aes_block_t               resp_data;
  logic       [ID_W-1:0]    resp_id;
  logic                     resp_err;

  modport master (
    output req_valid, req_key, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_key, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
endinterface

// File: rtl/aes_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    // Scan from farthest to nearest so the closest request to ptr wins last.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NUM_REQ])
        idx = ID_W'((int'(ptr) + off) % NUM_REQ);
    end
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES core among NUM_REQ requesters, with watchdog.
// Optional statistics counters are enabled by defining AES_ARB_STATS_EN.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic       clk,
  input  logic       rst,
  aes_req_arbiter_if.slave bus,
  output logic       core_rst,
  output aes_block_t core_key,
  output aes_block_t core_data,
  input  logic       core_done,
  input  aes_block_t core_result,
  output logic       busy
`ifdef AES_ARB_STATS_EN
  ,
  output logic [31:0] stat_done_cnt,
  output logic [15:0] stat_timeout_cnt
`endif
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e           state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_any;
  logic [WD_W-1:0]      wd_cnt;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The core is held in reset with the arbiter and pulsed once per job in LOAD.
  assign core_rst = rst | (state == LOAD);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      wd_cnt         <= '0;
      bus.req_ready  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
      bus.resp_err   <= 1'b0;
      core_key       <= '0;
      core_data      <= '0;
`ifdef AES_ARB_STATS_EN
      stat_done_cnt    <= '0;
      stat_timeout_cnt <= '0;
`endif
    end else begin
      bus.req_ready <= '0;
      case (state)
        IDLE: if (pick_any) begin
          bus.req_ready <= pick_gnt;
          core_key      <= bus.req_key[pick_idx];
          core_data     <= bus.req_data[pick_idx];
          bus.resp_id   <= pick_idx;
          ptr           <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          state         <= LOAD;
        end
        LOAD: begin
          wd_cnt <= '0;
          state  <= RUN;
        end
        RUN: begin
          // wd_cnt==0 marks the first RUN cycle, where a stale done may linger.
          if (wd_cnt != '0 && core_done) begin
            bus.resp_data  <= core_result;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
`ifdef AES_ARB_STATS_EN
          if (!bus.resp_err) begin
            if (stat_done_cnt != '1) stat_done_cnt <= stat_done_cnt + 32'd1;
          end else begin
            if (stat_timeout_cnt != '1) stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
